// File: rtl/burst_pkg.sv
// Shared types and constants for the normal-burst assembler: FSM states,
// field boundaries, the training-sequence ROM and the per-index symbol source.
package burst_pkg;

    typedef enum logic [2:0] {
        EMPTY   = 3'd0,
        LOADING = 3'd1,
        ARMED   = 3'd2,
        BURST   = 3'd3,
        GUARD   = 3'd4
    } burst_state_t;

    localparam int PAYLOAD_BITS = 116;
    localparam int TAIL_BITS    = 3;
    localparam int TSC_BITS     = 26;
    localparam int BUF_BITS     = 120;

    localparam logic [3:0] PAYLOAD_BYTES = 4'd15;
    localparam logic [3:0] GUARD_SYMBOLS = 4'd8;

    localparam logic [7:0] TAIL_END      = 8'd3;
    localparam logic [7:0] PAYLOAD_A_END = 8'd61;
    localparam logic [7:0] TSC_END       = 8'd87;
    localparam logic [7:0] PAYLOAD_B_END = 8'd145;
    localparam logic [7:0] BURST_LEN     = 8'd148;

    localparam logic [TSC_BITS-1:0] TSC_ROM [0:7] = '{
        26'h0970897, 26'h0B778B7, 26'h10EE90E, 26'h11ED11E,
        26'h06B906B, 26'h13AC13A, 26'h29F629F, 26'h3BC4BBC
    };

    // Byte 0 sits in the top byte of the buffer, so payload bit k is buf[119-k].
    function automatic logic burst_source(input logic [BUF_BITS-1:0] payload,
                                          input logic [TSC_BITS-1:0] tsc,
                                          input logic [7:0]          idx);
        logic       bit_val;
        logic [6:0] ppos;
        logic [4:0] tpos;
        bit_val = 1'b0;
        ppos    = 7'd0;
        tpos    = 5'd0;
        if (idx < TAIL_END) begin
            bit_val = 1'b0;
        end else if (idx < PAYLOAD_A_END) begin
            ppos    = 7'(8'd122 - idx);
            bit_val = payload[ppos];
        end else if (idx < TSC_END) begin
            tpos    = 5'(8'd86 - idx);
            bit_val = tsc[tpos];
        end else if (idx < PAYLOAD_B_END) begin
            ppos    = 7'(8'd148 - idx);
            bit_val = payload[ppos];
        end
        return bit_val;
    endfunction

endpackage

// File: rtl/burst_assembler_diff_encoder.sv
// Differential GMSK pre-encoder: symbol = ~(d[i] ^ d[i-1]), d[-1] = 1.
// Present only when GMSK_DIFF_ENCODE_EN is defined.
`ifdef GMSK_DIFF_ENCODE_EN
module gmsk_diff_encoder (
    input  logic clock,
    input  logic reset,
    input  logic data_bit,
    input  logic advance,
    input  logic clear,
    output logic symbol
);

    logic prev;
    logic prev_eff;

    // clear substitutes d[-1] = 1 for the first symbol of a burst
    assign prev_eff = clear ? 1'b1 : prev;
    assign symbol   = ~(data_bit ^ prev_eff);

    always_ff @(posedge clock) begin
        if (!reset) begin
            prev <= 1'b1;
        end else if (advance) begin
            prev <= data_bit;
        end else if (clear) begin
            prev <= 1'b1;
        end
    end

endmodule
`endif

// File: rtl/burst_assembler.sv
// Normal-burst assembler: loads a 15-byte payload, then emits tail/payload/TSC/
// payload/tail symbols on modulator strobes, followed by guard. Option: GMSK_DIFF_ENCODE_EN.
module burst_assembler
    import burst_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] tsc_sel,
    input  logic       start,
    output logic       armed,
    input  logic       symbol_strobe,
    output logic       symbol,
    output logic       in_burst,
    output logic [7:0] symbol_index,
    output logic       burst_done,
    output logic [2:0] state_dbg
);

    // Write handshake: a byte transfers on every clock edge where wr_valid and
    // wr_ready are both high; wr_valid with wr_ready low drops the byte.
    burst_state_t        state, state_next;
    logic                strobe_q, strobe_ev;
    logic [BUF_BITS-1:0] payload;
    logic [3:0]          byte_count;
    logic                pending;
    logic [2:0]          tsc_idx_q;
    logic [3:0]          guard_cnt;
    logic                accept_byte, fire, burst_step, burst_end, guard_end;
    logic [7:0]          next_index;
    logic                next_raw, next_symbol;

    assign strobe_ev = symbol_strobe & ~strobe_q;

    always_ff @(posedge clock) begin
        if (!reset) state <= EMPTY;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        wr_ready    = 1'b0;
        accept_byte = 1'b0;
        fire        = 1'b0;
        burst_step  = 1'b0;
        burst_end   = 1'b0;
        guard_end   = 1'b0;
        case (state)
            EMPTY, LOADING: begin
                wr_ready    = 1'b1;
                accept_byte = wr_valid;
                if (wr_valid) begin
                    if (byte_count == PAYLOAD_BYTES - 4'd1) state_next = ARMED;
                    else                                    state_next = LOADING;
                end
            end
            ARMED: begin
                if (strobe_ev && (pending || start)) begin
                    fire       = 1'b1;
                    state_next = BURST;
                end
            end
            BURST: begin
                if (strobe_ev) begin
                    if (symbol_index == BURST_LEN - 8'd1) begin
                        burst_end  = 1'b1;
                        state_next = GUARD;
                    end else begin
                        burst_step = 1'b1;
                    end
                end
            end
            GUARD: begin
                if (strobe_ev && guard_cnt == GUARD_SYMBOLS - 4'd1) begin
                    guard_end  = 1'b1;
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    assign armed     = (state == ARMED);
    assign in_burst  = (state == BURST);
    assign state_dbg = state;

    assign next_index = fire ? 8'd0 : symbol_index + 8'd1;
    assign next_raw   = burst_source(payload, TSC_ROM[tsc_idx_q], next_index);

`ifdef GMSK_DIFF_ENCODE_EN
    gmsk_diff_encoder u_diff (
        .clock    (clock),
        .reset    (reset),
        .data_bit (next_raw),
        .advance  (fire | burst_step),
        .clear    (fire),
        .symbol   (next_symbol)
    );
`else
    assign next_symbol = next_raw;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            strobe_q     <= 1'b0;
            payload      <= '0;
            byte_count   <= 4'd0;
            pending      <= 1'b0;
            tsc_idx_q    <= 3'd0;
            guard_cnt    <= 4'd0;
            symbol_index <= 8'd0;
            symbol       <= 1'b1;
            burst_done   <= 1'b0;
        end else begin
            strobe_q   <= symbol_strobe;
            burst_done <= 1'b0;
            if (accept_byte) begin
                payload    <= {payload[BUF_BITS-9:0], wr_data};
                byte_count <= byte_count + 4'd1;
            end
            if (state == ARMED && start) begin
                pending   <= 1'b1;
                tsc_idx_q <= tsc_sel;
            end
            if (fire) pending <= 1'b0;
            if (fire || burst_step) begin
                symbol_index <= next_index;
                symbol       <= next_symbol;
            end
            // the strobe that ends the burst is the first of the guard symbols
            if (burst_end) begin
                symbol_index <= 8'd0;
                symbol       <= 1'b1;
                guard_cnt    <= 4'd1;
            end
            if (state == GUARD && strobe_ev && !guard_end) guard_cnt <= guard_cnt + 4'd1;
            if (guard_end) begin
                burst_done <= 1'b1;
                payload    <= '0;
                byte_count <= 4'd0;
                guard_cnt  <= 4'd0;
            end
        end
    end

endmodule
